seven_seg_scan_driver: RTL

// - Time-multiplexed scan engine for the 3-digit 7-segment display. Sits directly downstream of the GPIO bus

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_hex_decode.sv | 13 +
 rtl/seven_seg_scan_driver.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver.
//   NUM_DIGITS   : number of display digits scanned
//   scan_state_e : scan FSM state encoding
//   HEX_FONT     : nibble -> segments (bit0=a .. bit6=g), logical active-high
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 3;

    typedef enum logic {
        StBlank = 1'b0,
        StDrive = 1'b1
    } scan_state_e;

    // Index 15 is leftmost: F E d C b A 9 8 7 6 5 4 3 2 1 0
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-digit font lookup.
//   i_Nibble : hex value 0-F
//   o_Seg    : segment pattern, bit0=a .. bit6=g, active-high
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_Nibble,
    output logic [6:0] o_Seg
);

    assign o_Seg = HEX_FONT[i_Nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed scan engine for a 3-digit 7-segment display. Each digit slot is an optional
// all-off blanking interval followed by a drive interval. Inputs are captured once per frame at
// the start of digit 0's slot so a mid-frame update never tears the displayed frame.
//   i_Clk       : system clock, posedge
//   i_Rst       : synchronous reset, active-high
//   i_HexLutEn  : 1 = low nibble of each segment input goes through the hex font
//   i_SegOne    : digit 0 value (raw: bit0=a .. bit6=g)
//   i_SegTwo    : digit 1 value
//   i_SegThree  : digit 2 value
//   o_7Seg_En   : one-hot digit enable, polarity per EN_ACTIVE_LOW
//   o_7Seg_Led  : segment drive, polarity per LED_ACTIVE_LOW
//   o_FrameDone : one-cycle pulse after the last drive cycle of digit 2
module seven_seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGIT_TICKS    = 32768,
    parameter int unsigned BLANK_TICKS    = 1024,
    parameter bit          EN_ACTIVE_LOW  = 1'b1,
    parameter bit          LED_ACTIVE_LOW = 1'b0
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_HexLutEn,
    input  logic [6:0] i_SegOne,
    input  logic [6:0] i_SegTwo,
    input  logic [6:0] i_SegThree,
    output logic [2:0] o_7Seg_En,
    output logic [6:0] o_7Seg_Led,
    output logic       o_FrameDone
);

    localparam int unsigned MAX_TICKS =
        (DIGIT_TICKS > BLANK_TICKS) ? ((DIGIT_TICKS > 2) ? DIGIT_TICKS : 2)
                                    : ((BLANK_TICKS > 2) ? BLANK_TICKS : 2);
    localparam int unsigned CNT_W = $clog2(MAX_TICKS);

    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_TICKS - 1);
    // Unreachable when blanking is disabled; kept at zero to stay in range.
    localparam logic [CNT_W-1:0] BLANK_LAST =
        (BLANK_TICKS == 0) ? '0 : CNT_W'(BLANK_TICKS - 1);

    // First state of every digit slot.
    localparam scan_state_e SLOT_START = (BLANK_TICKS == 0) ? StDrive : StBlank;

    localparam logic [1:0] LAST_DIGIT = 2'(NUM_DIGITS - 1);
    localparam logic [2:0] EN_OFF     = {3{EN_ACTIVE_LOW}};
    localparam logic [6:0] LED_OFF    = {7{LED_ACTIVE_LOW}};

    scan_state_e      r_state;
    logic [1:0]       r_digit;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_shadow_one;
    logic [6:0]       r_shadow_two;
    logic [6:0]       r_shadow_three;
    logic             r_shadow_lut;
    logic [2:0]       r_en;
    logic [6:0]       r_led;
    logic             r_frame_done;

    logic       w_latch;
    logic       w_lut;
    logic [6:0] w_raw;
    logic [6:0] w_font;
    logic [6:0] w_seg;
    logic       w_digit_last;
    logic       w_drive_end;
    logic [2:0] w_onehot;

    assign w_latch = (r_state == SLOT_START) && (r_digit == 2'd0) && (r_cnt == '0);

    // When blanking is disabled the latch cycle is already a drive cycle, so the output
    // register must see the values being captured rather than the stale shadows.
    assign w_lut = w_latch ? i_HexLutEn : r_shadow_lut;

    always_comb begin
        w_raw = 7'h00;
        unique case (r_digit)
            2'd0:    w_raw = w_latch ? i_SegOne : r_shadow_one;
            2'd1:    w_raw = r_shadow_two;
            2'd2:    w_raw = r_shadow_three;
            default: w_raw = 7'h00;
        endcase
    end

    seg7_hex_decode u_hex_decode (
        .i_Nibble (w_raw[3:0]),
        .o_Seg    (w_font)
    );

    assign w_seg        = w_lut ? w_font : w_raw;
    assign w_digit_last = (r_digit == LAST_DIGIT);
    assign w_drive_end  = (r_state == StDrive) && (r_cnt == DIGIT_LAST);
    assign w_onehot     = 3'b001 << r_digit;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state        <= SLOT_START;
            r_digit        <= 2'd0;
            r_cnt          <= '0;
            r_shadow_one   <= 7'h00;
            r_shadow_two   <= 7'h00;
            r_shadow_three <= 7'h00;
            r_shadow_lut   <= 1'b0;
            r_en           <= EN_OFF;
            r_led          <= LED_OFF;
            r_frame_done   <= 1'b0;
        end else begin
            if (w_latch) begin
                r_shadow_one   <= i_SegOne;
                r_shadow_two   <= i_SegTwo;
                r_shadow_three <= i_SegThree;
                r_shadow_lut   <= i_HexLutEn;
            end

            case (r_state)
                StBlank: begin
                    if (r_cnt == BLANK_LAST) begin
                        r_state <= StDrive;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StDrive: begin
                    if (w_drive_end) begin
                        r_state <= SLOT_START;
                        r_cnt   <= '0;
                        r_digit <= w_digit_last ? 2'd0 : r_digit + 2'd1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= SLOT_START;
                    r_cnt   <= '0;
                end
            endcase

            // Polarity is applied only here; everything upstream is logical active-high.
            if (r_state == StDrive) begin
                r_en  <= w_onehot ^ EN_OFF;
                r_led <= w_seg ^ LED_OFF;
            end else begin
                r_en  <= EN_OFF;
                r_led <= LED_OFF;
            end

            r_frame_done <= w_drive_end && w_digit_last;
        end
    end

    assign o_7Seg_En   = r_en;
    assign o_7Seg_Led  = r_led;
    assign o_FrameDone = r_frame_done;

endmodule
